// File: rtl/aximm_test0_hls_deadlock_pkg.sv
// Shared definitions for the HLS dataflow deadlock report unit: FSM encoding
// and the width helpers used to size process IDs and path lengths.
package aximm_test0_hls_deadlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ORIGIN = 3'd1,
    ST_TRACE  = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } dl_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A single process still needs a one-bit ID field.
  function automatic int id_width(input int proc_num);
    return (clog2(proc_num) < 1) ? 1 : clog2(proc_num);
  endfunction

  function automatic int len_width(input int path_depth);
    return clog2(path_depth + 1);
  endfunction

endpackage

// File: rtl/aximm_test0_hls_deadlock_prio_enc.sv
// Lowest-set-index priority encoder with an any-bit-set flag.
module aximm_test0_hls_deadlock_prio_enc
  import aximm_test0_hls_deadlock_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = id_width(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/aximm_test0_hls_deadlock_report_unit.sv
// Central deadlock report unit: picks an origin, follows the token around the
// dependence cycle, and reports the recorded path over a valid/ready handshake.
module aximm_test0_hls_deadlock_report_unit
  import aximm_test0_hls_deadlock_pkg::*;
#(
  parameter int  PROC_NUM   = 4,
  parameter int  PATH_DEPTH = PROC_NUM,
  parameter int  TIMEOUT    = 16,
  localparam int ID_W       = id_width(PROC_NUM),
  localparam int LEN_W      = len_width(PATH_DEPTH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [PROC_NUM-1:0]        dl_detect_vec,
  input  logic [PROC_NUM-1:0]        token_vec,
  output logic                       dl_detect_in,
  output logic [PROC_NUM-1:0]        origin,
  output logic                       token_clear,
  output logic                       dl_flag,
  output logic                       rpt_vld,
  input  logic                       rpt_rdy,
  output logic [ID_W-1:0]            rpt_origin,
  output logic [LEN_W-1:0]           rpt_len,
  output logic [PATH_DEPTH*ID_W-1:0] rpt_path,
  output logic                       rpt_closed,
  output logic                       rpt_timeout,
  output logic                       rpt_trunc
);

  localparam int CNT_W = clog2(TIMEOUT + 1);

  dl_state_e           state_q, state_d;
  logic [ID_W-1:0]     org_q, org_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     path_q [PATH_DEPTH];
  logic                path_we;
  logic [LEN_W-1:0]    path_wa;
  logic [ID_W-1:0]     path_wd;
  logic [ID_W-1:0]     det_idx, tok_idx;
  logic                det_any, tok_any;
  logic                flag_d, vld_d, closed_d, tmo_d, trunc_d, det_in_d;
  logic [PROC_NUM-1:0] origin_d;

  aximm_test0_hls_deadlock_prio_enc #(.N(PROC_NUM), .IDX_W(ID_W)) u_det_enc (
    .vec (dl_detect_vec),
    .idx (det_idx),
    .any (det_any)
  );

  aximm_test0_hls_deadlock_prio_enc #(.N(PROC_NUM), .IDX_W(ID_W)) u_tok_enc (
    .vec (token_vec),
    .idx (tok_idx),
    .any (tok_any)
  );

  always_comb begin
    state_d     = state_q;
    org_d       = org_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    flag_d      = dl_flag;
    vld_d       = rpt_vld;
    closed_d    = rpt_closed;
    tmo_d       = rpt_timeout;
    trunc_d     = rpt_trunc;
    path_we     = 1'b0;
    path_wa     = '0;
    path_wd     = '0;
    token_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (det_any) begin
          org_d   = det_idx;
          flag_d  = 1'b1;
          state_d = ST_ORIGIN;
        end
      end
      ST_ORIGIN: begin
        path_we = 1'b1;
        path_wa = '0;
        path_wd = org_q;
        len_d   = LEN_W'(1);
        cnt_d   = '0;
        state_d = ST_TRACE;
      end
      ST_TRACE: begin
        if (!tok_any) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            token_clear = 1'b1;
            tmo_d       = 1'b1;
            vld_d       = 1'b1;
            state_d     = ST_REPORT;
          end
        end else if (tok_idx == org_q) begin
          token_clear = 1'b1;
          closed_d    = 1'b1;
          vld_d       = 1'b1;
          state_d     = ST_REPORT;
        end else if (len_q < LEN_W'(PATH_DEPTH)) begin
          // A token parked on one process appends every cycle: a self-loop.
          path_we = 1'b1;
          path_wa = len_q;
          path_wd = tok_idx;
          len_d   = len_q + LEN_W'(1);
          cnt_d   = '0;
        end else begin
          token_clear = 1'b1;
          trunc_d     = 1'b1;
          vld_d       = 1'b1;
          state_d     = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (rpt_rdy) begin
          vld_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_DONE;
      end
    endcase
    det_in_d = (state_d != ST_IDLE);
    origin_d = (state_d == ST_ORIGIN) ? (PROC_NUM'(1) << org_d) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      org_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      dl_detect_in <= 1'b0;
      origin       <= '0;
      dl_flag      <= 1'b0;
      rpt_vld      <= 1'b0;
      rpt_closed   <= 1'b0;
      rpt_timeout  <= 1'b0;
      rpt_trunc    <= 1'b0;
    end else begin
      state_q      <= state_d;
      org_q        <= org_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      dl_detect_in <= det_in_d;
      origin       <= origin_d;
      dl_flag      <= flag_d;
      rpt_vld      <= vld_d;
      rpt_closed   <= closed_d;
      rpt_timeout  <= tmo_d;
      rpt_trunc    <= trunc_d;
    end
  end

  // Path entries carry no reset; stale entries are hidden by the length mask.
  always_ff @(posedge clock) begin
    for (int k = 0; k < PATH_DEPTH; k++) begin
      if (path_we && (path_wa == LEN_W'(k))) path_q[k] <= path_wd;
    end
  end

  assign rpt_origin = org_q;
  assign rpt_len    = len_q;

  always_comb begin
    rpt_path = '0;
    for (int k = 0; k < PATH_DEPTH; k++) begin
      if (LEN_W'(k) < len_q) rpt_path[k*ID_W +: ID_W] = path_q[k];
    end
  end

endmodule
